// File: rtl/alu_op_scheduler.sv
// Round-robin scheduler sharing one ALU between requesters A and B. It registers the
// operands, waits a fixed settle time, captures the result, and returns it to the winner.
module alu_op_scheduler #(
  parameter int WIDTH  = 5,
  parameter int SETTLE = 2,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_req_valid,
  output logic             a_req_ready,
  input  logic [1:0]       a_op,
  input  logic [WIDTH-1:0] a_x,
  input  logic [WIDTH-1:0] a_y,
  output logic             a_resp_valid,
  input  logic             a_resp_ready,
  input  logic             b_req_valid,
  output logic             b_req_ready,
  input  logic [1:0]       b_op,
  input  logic [WIDTH-1:0] b_x,
  input  logic [WIDTH-1:0] b_y,
  output logic             b_resp_valid,
  input  logic             b_resp_ready,
  output logic [WIDTH-1:0] resp_f,
  output logic             resp_cout,
  output logic             resp_ovf,
  output logic [WIDTH-1:0] alu_x,
  output logic [WIDTH-1:0] alu_y,
  output logic [1:0]       alu_s,
  input  logic [WIDTH-1:0] alu_f,
  input  logic             alu_cout,
  input  logic             alu_ovf,
  output logic             busy,
  output logic [CNT_W-1:0] ops_done,
  output logic [1:0]       state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // Ready never depends on the same channel's data; resp_valid holds until resp_ready.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic GRANT_A = 1'b0;
  localparam logic GRANT_B = 1'b1;
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t     state_q, state_nxt;
  logic       owner_q;
  logic       last_grant_q;
  logic [3:0] cnt_q;
  logic       capture;
  logic       resp_fire;

  always_comb begin
    state_nxt    = state_q;
    a_req_ready  = 1'b0;
    b_req_ready  = 1'b0;
    a_resp_valid = 1'b0;
    b_resp_valid = 1'b0;
    capture      = 1'b0;
    resp_fire    = 1'b0;
    case (state_q)
      IDLE: begin
        a_req_ready = a_req_valid & (!b_req_valid | (last_grant_q == GRANT_B));
        b_req_ready = b_req_valid & (!a_req_valid | (last_grant_q == GRANT_A));
        if (a_req_ready || b_req_ready) state_nxt = WAIT;
      end
      WAIT: begin
        if (cnt_q == SETTLE_LAST) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        a_resp_valid = (owner_q == GRANT_A);
        b_resp_valid = (owner_q == GRANT_B);
        // Only the owner's ready can retire the response.
        resp_fire    = (owner_q == GRANT_A) ? a_resp_ready : b_resp_ready;
        if (resp_fire) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= GRANT_A;
      last_grant_q <= GRANT_B;
      cnt_q        <= 4'd0;
      alu_x        <= '0;
      alu_y        <= '0;
      alu_s        <= 2'b00;
      resp_f       <= '0;
      resp_cout    <= 1'b0;
      resp_ovf     <= 1'b0;
      ops_done     <= '0;
    end else begin
      state_q <= state_nxt;
      if (a_req_ready) begin
        alu_x        <= a_x;
        alu_y        <= a_y;
        alu_s        <= a_op;
        owner_q      <= GRANT_A;
        last_grant_q <= GRANT_A;
        cnt_q        <= 4'd0;
      end else if (b_req_ready) begin
        alu_x        <= b_x;
        alu_y        <= b_y;
        alu_s        <= b_op;
        owner_q      <= GRANT_B;
        last_grant_q <= GRANT_B;
        cnt_q        <= 4'd0;
      end
      if (state_q == WAIT) cnt_q <= cnt_q + 4'd1;
      // The ALU is only trusted on the capture edge; it is free-running otherwise.
      if (capture) begin
        resp_f    <= alu_f;
        resp_cout <= alu_cout;
        resp_ovf  <= alu_ovf;
      end
      if (resp_fire) ops_done <= ops_done + 1'b1;
    end
  end

  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Directed bench for alu_op_scheduler: two DUTs run in lockstep (CNT_W=8 and CNT_W=2),
// each driving its own behavioural ALU.
module tb_alu_op_scheduler;

  localparam int W = 5;
  localparam int SETTLE = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         a_req_valid = 1'b0, b_req_valid = 1'b0;
  logic [1:0]   a_op = 2'b00, b_op = 2'b00;
  logic [W-1:0] a_x = '0, a_y = '0, b_x = '0, b_y = '0;
  logic         a_resp_ready = 1'b0, b_resp_ready = 1'b0;

  logic         a_req_ready, b_req_ready, a_resp_valid, b_resp_valid;
  logic [W-1:0] resp_f, alu_x, alu_y, alu_f;
  logic         resp_cout, resp_ovf, alu_cout, alu_ovf, busy;
  logic [1:0]   alu_s, state_dbg;
  logic [7:0]   ops_done;

  logic         u2_a_req_ready, u2_b_req_ready, u2_a_resp_valid, u2_b_resp_valid;
  logic [W-1:0] u2_resp_f, u2_alu_x, u2_alu_y, u2_alu_f;
  logic         u2_resp_cout, u2_resp_ovf, u2_alu_cout, u2_alu_ovf, u2_busy;
  logic [1:0]   u2_alu_s, u2_state_dbg;
  logic [1:0]   u2_ops_done;

  int n_tests = 0;
  int n_fail  = 0;

  // ALU: 00 multiply, 01 compare, 10 add, 11 add-and-shift. Returns {ovf, cout, f}.
  function automatic logic [6:0] alu_model(input logic [4:0] x, input logic [4:0] y,
                                           input logic [1:0] s);
    logic [9:0] p;
    logic [5:0] sum;
    logic [6:0] r;
    p   = 10'(x) * 10'(y);
    sum = 6'(x) + 6'(y);
    case (s)
      2'b00:   r = {|p[9:5], |p[9:5], p[4:0]};
      2'b01:   r = {2'b00, 2'b00, (x > y), (x == y), (x < y)};
      2'b10:   r = {(x[4] == y[4]) && (sum[4] != x[4]), sum[5], sum[4:0]};
      default: r = {(x[4] == y[4]) && (sum[4] != x[4]), sum[0], sum[5:1]};
    endcase
    return r;
  endfunction

  assign {alu_ovf, alu_cout, alu_f}          = alu_model(alu_x, alu_y, alu_s);
  assign {u2_alu_ovf, u2_alu_cout, u2_alu_f} = alu_model(u2_alu_x, u2_alu_y, u2_alu_s);

  alu_op_scheduler #(.WIDTH(W), .SETTLE(SETTLE), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_op(a_op), .a_x(a_x), .a_y(a_y),
    .a_resp_valid(a_resp_valid), .a_resp_ready(a_resp_ready),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_op(b_op), .b_x(b_x), .b_y(b_y),
    .b_resp_valid(b_resp_valid), .b_resp_ready(b_resp_ready),
    .resp_f(resp_f), .resp_cout(resp_cout), .resp_ovf(resp_ovf),
    .alu_x(alu_x), .alu_y(alu_y), .alu_s(alu_s),
    .alu_f(alu_f), .alu_cout(alu_cout), .alu_ovf(alu_ovf),
    .busy(busy), .ops_done(ops_done), .state_dbg(state_dbg)
  );

  alu_op_scheduler #(.WIDTH(W), .SETTLE(SETTLE), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst),
    .a_req_valid(a_req_valid), .a_req_ready(u2_a_req_ready), .a_op(a_op), .a_x(a_x), .a_y(a_y),
    .a_resp_valid(u2_a_resp_valid), .a_resp_ready(a_resp_ready),
    .b_req_valid(b_req_valid), .b_req_ready(u2_b_req_ready), .b_op(b_op), .b_x(b_x), .b_y(b_y),
    .b_resp_valid(u2_b_resp_valid), .b_resp_ready(b_resp_ready),
    .resp_f(u2_resp_f), .resp_cout(u2_resp_cout), .resp_ovf(u2_resp_ovf),
    .alu_x(u2_alu_x), .alu_y(u2_alu_y), .alu_s(u2_alu_s),
    .alu_f(u2_alu_f), .alu_cout(u2_alu_cout), .alu_ovf(u2_alu_ovf),
    .busy(u2_busy), .ops_done(u2_ops_done), .state_dbg(u2_state_dbg)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete A transaction with latency, result, counter and hold checks.
  task automatic run_a(input logic [1:0] op, input logic [4:0] x, input logic [4:0] y,
                       input logic [4:0] ef, input logic ec, input logic eo,
                       input logic [7:0] edone);
    int lat;
    a_op = op; a_x = x; a_y = y; a_req_valid = 1'b1;
    #1;
    check("a_req_ready", a_req_ready, 1);
    tick();
    a_req_valid = 1'b0;
    check("alu_s", alu_s, op);
    check("alu_x", alu_x, x);
    check("alu_y", alu_y, y);
    check("busy_wait", busy, 1);
    lat = 0;
    while (!a_resp_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("resp_latency", lat, SETTLE);
    check("resp_f", resp_f, ef);
    check("resp_cout", resp_cout, ec);
    check("resp_ovf", resp_ovf, eo);
    check("b_resp_valid_idle", b_resp_valid, 0);
    check("u2_a_resp_valid", u2_a_resp_valid, 1);
    a_resp_ready = 1'b1;
    tick();
    a_resp_ready = 1'b0;
    check("ops_done", ops_done, edone);
    check("u2_ops_done", u2_ops_done, edone[1:0]);
    check("a_resp_valid_done", a_resp_valid, 0);
    check("busy_done", busy, 0);
    check("alu_x_hold", alu_x, x);
    check("alu_y_hold", alu_y, y);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_state", state_dbg, 0);
    check("rst_alu_s", alu_s, 0);
    check("rst_alu_x", alu_x, 0);
    check("rst_resp_f", resp_f, 0);
    check("rst_ops_done", ops_done, 0);
    check("rst_a_resp_valid", a_resp_valid, 0);
    check("rst_b_resp_valid", b_resp_valid, 0);
    check("rst_a_req_ready", a_req_ready, 0);

    // Add 00010 + 11010 = 11100, then signed overflow 01111 + 01111
    run_a(2'b10, 5'b00010, 5'b11010, 5'b11100, 1'b0, 1'b0, 8'd1);
    run_a(2'b10, 5'b01111, 5'b01111, 5'b11110, 1'b0, 1'b1, 8'd2);

    // Arbitration from reset: A first, then alternation A, B, A, B
    rst = 1'b1; tick(); rst = 1'b0;
    a_op = 2'b10; a_x = 5'd1; a_y = 5'd1; a_req_valid = 1'b1;
    b_op = 2'b10; b_x = 5'd3; b_y = 5'd4; b_req_valid = 1'b1;
    #1;
    check("tie1_a_ready", a_req_ready, 1);
    check("tie1_b_ready", b_req_ready, 0);
    tick();
    a_req_valid = 1'b0;
    check("wait_b_ready", b_req_ready, 0);
    tick(); tick();
    check("op1_a_resp_valid", a_resp_valid, 1);
    check("op1_resp_f", resp_f, 5'd2);
    // Backpressure with B waiting and a non-owner ready asserted
    b_resp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_a_resp_valid", a_resp_valid, 1);
      check("bp_b_resp_valid", b_resp_valid, 0);
      check("bp_resp_f", resp_f, 5'd2);
      check("bp_b_ready", b_req_ready, 0);
      check("bp_busy", busy, 1);
    end
    b_resp_ready = 1'b0;
    check("bp_ops_done", ops_done, 0);
    a_resp_ready = 1'b1; tick(); a_resp_ready = 1'b0;
    a_op = 2'b00; a_x = 5'd3; a_y = 5'd5; a_req_valid = 1'b1;
    #1;
    check("tie2_b_ready", b_req_ready, 1);
    check("tie2_a_ready", a_req_ready, 0);
    tick();
    b_req_valid = 1'b0;
    check("op2_alu_x", alu_x, 5'd3);
    check("op2_alu_y", alu_y, 5'd4);
    tick(); tick();
    check("op2_b_resp_valid", b_resp_valid, 1);
    check("op2_a_resp_valid", a_resp_valid, 0);
    check("op2_resp_f", resp_f, 5'd7);
    b_resp_ready = 1'b1; tick(); b_resp_ready = 1'b0;
    b_op = 2'b10; b_x = 5'b11111; b_y = 5'b00001; b_req_valid = 1'b1;
    #1;
    check("tie3_a_ready", a_req_ready, 1);
    check("tie3_b_ready", b_req_ready, 0);
    tick();
    a_req_valid = 1'b0;
    tick(); tick();
    check("op3_a_resp_valid", a_resp_valid, 1);
    check("op3_mul_f", resp_f, 5'd15);
    check("op3_mul_cout", resp_cout, 0);
    a_resp_ready = 1'b1; tick(); a_resp_ready = 1'b0;
    #1;
    check("op4_b_ready", b_req_ready, 1);
    tick();
    b_req_valid = 1'b0;
    tick(); tick();
    check("op4_b_resp_valid", b_resp_valid, 1);
    check("op4_resp_f", resp_f, 5'd0);
    check("op4_resp_cout", resp_cout, 1);
    check("op4_resp_ovf", resp_ovf, 0);
    b_resp_ready = 1'b1; tick(); b_resp_ready = 1'b0;
    check("arb_ops_done", ops_done, 4);
    check("arb_u2_ops_done", u2_ops_done, 0);

    // Reset while waiting on the ALU aborts the operation
    a_op = 2'b10; a_x = 5'd5; a_y = 5'd5; a_req_valid = 1'b1;
    tick();
    a_req_valid = 1'b0;
    tick();
    check("abort_busy_before", busy, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_alu_x", alu_x, 0);
    check("abort_alu_y", alu_y, 0);
    check("abort_alu_s", alu_s, 0);
    check("abort_resp_f", resp_f, 0);
    check("abort_ops_done", ops_done, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("abort_no_resp", a_resp_valid, 0);
    end
    run_a(2'b10, 5'd4, 5'd5, 5'd9, 1'b0, 1'b0, 8'd1);

    // Counter wrap on the CNT_W=2 instance: 1,2,3,0,1
    rst = 1'b1; tick(); rst = 1'b0;
    run_a(2'b10, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 8'd1);
    run_a(2'b11, 5'd6, 5'd3, 5'd4, 1'b1, 1'b0, 8'd2);
    run_a(2'b01, 5'd7, 5'd7, 5'd2, 1'b0, 1'b0, 8'd3);
    run_a(2'b00, 5'd8, 5'd4, 5'd0, 1'b1, 1'b1, 8'd4);
    run_a(2'b10, 5'd10, 5'd11, 5'd21, 1'b0, 1'b1, 8'd5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
